traffic_sequencer: RTL and testbench

- Timing and state controller that drives the 2-bit light selection code into the RGB LED colour stage.
- Cycles Red -> Green -> Yellow -> Red, and inserts a Red & Walk phase when a pedestrian request is pending.
- All phase durations are set in milliseconds, derived from the master clock through an internal 1 ms prescaler.
- Sits between the debounced pedestrian button and the light stage; its outSel feeds that stage's selection input directly.

---
 rtl/traffic_sequencer.sv | 105 ++++++++++
 tb/tb_traffic_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/traffic_sequencer.sv
// Traffic light sequencer: Red -> Green -> Yellow -> Red, with a Red & Walk
// phase inserted after Yellow when a pedestrian request is pending.
module traffic_sequencer #(
  parameter int C_CLK_FRQ  = 100000000,
  parameter int C_T_RED    = 3000,
  parameter int C_T_GREEN  = 5000,
  parameter int C_T_YELLOW = 1000,
  parameter int C_T_WALK   = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inWalkReq,
  output logic [1:0] outSel,
  output logic       outWalkPend,
  output logic       outChange
);

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    WALK   = 2'b11
  } state_t;

  localparam int P      = C_CLK_FRQ / 1000;
  localparam int PRE_W  = (P > 1) ? $clog2(P) : 1;
  localparam int T_RG   = (C_T_RED > C_T_GREEN) ? C_T_RED : C_T_GREEN;
  localparam int T_YW   = (C_T_YELLOW > C_T_WALK) ? C_T_YELLOW : C_T_WALK;
  localparam int T_MAX  = (T_RG > T_YW) ? T_RG : T_YW;
  localparam int MS_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(P - 1);
  localparam logic [MS_W-1:0]  RED_LAST    = MS_W'(C_T_RED - 1);
  localparam logic [MS_W-1:0]  GREEN_LAST  = MS_W'(C_T_GREEN - 1);
  localparam logic [MS_W-1:0]  YELLOW_LAST = MS_W'(C_T_YELLOW - 1);
  localparam logic [MS_W-1:0]  WALK_LAST   = MS_W'(C_T_WALK - 1);

  state_t           state;
  state_t           next_state;
  logic [PRE_W-1:0] pre;
  logic [MS_W-1:0]  ms;
  logic [MS_W-1:0]  ms_last;
  logic             tick;
  logic             phase_end;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = RED;
    ms_last    = '0;
    case (state)
      RED: begin
        next_state = GREEN;
        ms_last    = RED_LAST;
      end
      GREEN: begin
        next_state = YELLOW;
        ms_last    = GREEN_LAST;
      end
      YELLOW: begin
        next_state = (outWalkPend || inWalkReq) ? WALK : RED;
        ms_last    = YELLOW_LAST;
      end
      WALK: begin
        next_state = RED;
        ms_last    = WALK_LAST;
      end
    endcase
  end

  assign tick      = (pre == PRE_LAST);
  assign phase_end = tick && (ms == ms_last);

  // Both counters restart at each phase change so every phase is exactly T*P cycles.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RED;
      outSel      <= 2'b00;
      outWalkPend <= 1'b0;
      outChange   <= 1'b0;
      pre         <= '0;
      ms          <= '0;
    end else begin
      outChange <= phase_end;
      if (phase_end) begin
        state  <= next_state;
        outSel <= next_state;
        pre    <= '0;
        ms     <= '0;
      end else if (tick) begin
        pre <= '0;
        ms  <= ms + MS_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end

      // Entering WALK serves the request; that clear beats a same-cycle set.
      if (phase_end && next_state == WALK)
        outWalkPend <= 1'b0;
      else if (inWalkReq && state != WALK)
        outWalkPend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer: normal cycle, walk insertion, request
// corner cases, asynchronous reset and the P=1 / T=1 corner.
module tb_traffic_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] sel;
  logic       pend;
  logic       chg;

  logic       rst_e;
  logic       req_e;
  logic [1:0] sel_e;
  logic       pend_e;
  logic       chg_e;

  int n_checks = 0;
  int n_errors = 0;
  bit pend_m   = 1'b0;

  always #5 clk = ~clk;

  traffic_sequencer #(
    .C_CLK_FRQ(10000), .C_T_RED(3), .C_T_GREEN(5), .C_T_YELLOW(2), .C_T_WALK(4)
  ) dut (
    .clk(clk), .rst(rst), .inWalkReq(req),
    .outSel(sel), .outWalkPend(pend), .outChange(chg)
  );

  traffic_sequencer #(
    .C_CLK_FRQ(1000), .C_T_RED(1), .C_T_GREEN(1), .C_T_YELLOW(1), .C_T_WALK(1)
  ) dut_edge (
    .clk(clk), .rst(rst_e), .inWalkReq(req_e),
    .outSel(sel_e), .outWalkPend(pend_e), .outChange(chg_e)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Observe one phase (or its first len cycles) at negedges. A request is driven
  // for phase cycles lo..hi; next_walk says this phase ends by entering WALK.
  task automatic run(input string tag, input logic [1:0] exp_sel, input int len,
                     input bit first_chg, input int lo, input int hi, input bit next_walk);
    bit r;
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s[%0d].sel", tag, i), 32'(sel), 32'(exp_sel));
      check($sformatf("%s[%0d].chg", tag, i), 32'(chg), 32'(first_chg && i == 0));
      check($sformatf("%s[%0d].pend", tag, i), 32'(pend), 32'(pend_m));
      r   = (i >= lo) && (i <= hi);
      req = r;
      if (i == len - 1 && next_walk) pend_m = 1'b0;
      else if (r && exp_sel != 2'b11) pend_m = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    rst_e = 1'b1;
    req   = 1'b0;
    req_e = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.sel", 32'(sel), 32'd0);
    check("reset.pend", 32'(pend), 32'd0);
    check("reset.chg", 32'(chg), 32'd0);
    rst = 1'b0;

    // Period 1: no requests, 30/50/20 cycles.
    run("p1_red", 2'b00, 30, 1'b0, -1, -1, 1'b0);
    run("p1_green", 2'b01, 50, 1'b1, -1, -1, 1'b0);
    run("p1_yellow", 2'b10, 20, 1'b1, -1, -1, 1'b0);

    // Period 2: one-cycle request 10 cycles into GREEN (cycle 40 of the period).
    run("p2_red", 2'b00, 30, 1'b1, -1, -1, 1'b0);
    run("p2_green", 2'b01, 50, 1'b1, 10, 10, 1'b0);
    run("p2_yellow", 2'b10, 20, 1'b1, -1, -1, 1'b1);
    // Request held through all of WALK and the first RED cycle.
    run("p2_walk", 2'b11, 40, 1'b1, 0, 39, 1'b0);
    run("p3_red", 2'b00, 30, 1'b1, 0, 0, 1'b0);
    run("p3_green", 2'b01, 50, 1'b1, -1, -1, 1'b0);
    run("p3_yellow", 2'b10, 20, 1'b1, -1, -1, 1'b1);
    run("p3_walk", 2'b11, 40, 1'b1, -1, -1, 1'b0);

    // Request only on the final YELLOW cycle: served, pending never rises.
    run("p4_red", 2'b00, 30, 1'b1, -1, -1, 1'b0);
    run("p4_green", 2'b01, 50, 1'b1, -1, -1, 1'b0);
    run("p4_yellow", 2'b10, 20, 1'b1, 19, 19, 1'b1);
    run("p4_walk", 2'b11, 40, 1'b1, -1, -1, 1'b0);

    // Asynchronous reset 25 cycles into GREEN with a request pending.
    run("p5_red", 2'b00, 30, 1'b1, -1, -1, 1'b0);
    run("p5_green", 2'b01, 25, 1'b1, 5, 5, 1'b0);
    check("pre_rst.pend", 32'(pend), 32'd1);
    check("pre_rst.sel", 32'(sel), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst.sel", 32'(sel), 32'd0);
    check("async_rst.pend", 32'(pend), 32'd0);
    check("async_rst.chg", 32'(chg), 32'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    pend_m = 1'b0;
    run("post_rst_red", 2'b00, 30, 1'b0, -1, -1, 1'b0);
    run("post_rst_green", 2'b01, 1, 1'b1, -1, -1, 1'b0);

    // P=1, all T=1: a new code every cycle, outChange continuously high.
    check("edge_reset.sel", 32'(sel_e), 32'd0);
    check("edge_reset.chg", 32'(chg_e), 32'd0);
    rst_e = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("edge[%0d].sel", i), 32'(sel_e), 32'(i % 3));
      check($sformatf("edge[%0d].chg", i), 32'(chg_e), 32'(i >= 1));
      check($sformatf("edge[%0d].pend", i), 32'(pend_e), 32'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
